instr_fetch: RTL and testbench

- Fetch stage that drives the instruction memory's combinational read port: supplies the 16-bit word address and captures the returned 16-bit instruction.
- Holds the program counter (PC) and registers each fetched instruction, with its PC, into an IF/ID output register.
- Hands instructions to decode over a valid/ready handshake.
- Supports decode back-pressure, branch redirect (BNE resolution) with flush, and halt past the end of the loaded program.

---
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch.sv | 69 ++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus: instruction memory read port plus IF/ID handshake
//
// Purpose: bundles the instruction memory read port and the IF/ID output
// register with its valid/ready handshake.
// Signals:
//   imem_addr  word address to instruction memory (fetch -> memory)
//   imem_data  instruction word for imem_addr, combinational (memory -> fetch)
//   if_valid   IF/ID register holds an instruction (fetch -> decode)
//   if_instr   fetched instruction word (fetch -> decode)
//   if_pc      address if_instr was fetched from (fetch -> decode)
//   id_ready   decode accepts if_instr this cycle (decode -> fetch)
interface instr_fetch_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_addr,
    input  imem_data,
    output if_valid,
    output if_instr,
    output if_pc,
    input  id_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with IF/ID register, redirect and halt
//
// Purpose: holds the PC, reads the combinational instruction memory and
// registers each word with its PC into the IF/ID register for decode.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   en           fetch enable; low freezes the PC (IF/ID may still drain)
//   redirect     branch taken: load redirect_pc and flush IF/ID
//   redirect_pc  branch target word address
//   halted       PC past the program and IF/ID empty
//   fetch_count  completed IF/ID handshakes, saturating at 16'hFFFF
//   bus          memory read port and IF/ID handshake (master side)
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  // 32-bit so that a program can cover every address including 16'hFFFF
  parameter int unsigned PROG_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [15:0] fetch_count,
  instr_fetch_if.master bus
);

  logic [15:0] pc;
  logic        xfer;
  logic        slot_free;
  logic        in_range;

  assign bus.imem_addr = pc;
  assign xfer          = bus.if_valid & bus.id_ready;
  assign slot_free     = ~bus.if_valid | bus.id_ready;
  assign in_range      = ({16'h0000, pc} < PROG_LEN);
  assign halted        = ~in_range & ~bus.if_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      bus.if_valid <= 1'b0;
      bus.if_instr <= 16'h0000;
      bus.if_pc    <= 16'h0000;
      fetch_count  <= 16'h0000;
    end else begin
      // A handshake completes even when a redirect flushes the register
      // in the same cycle: decode has already taken the word.
      if (xfer && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end

      if (redirect) begin
        // Target is fetched on the following cycle, never this one.
        pc           <= redirect_pc;
        bus.if_valid <= 1'b0;
      end else if (en && slot_free && in_range) begin
        bus.if_instr <= bus.imem_data;
        bus.if_pc    <= pc;
        bus.if_valid <= 1'b1;
        pc           <= pc + 16'd1;
      end else if (xfer) begin
        bus.if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk;
  logic        rst         [4];
  logic        en          [4];
  logic        redirect    [4];
  logic [15:0] redirect_pc [4];
  logic        halted      [4];
  logic [15:0] fetch_count [4];

  int checks;
  int failures;

  instr_fetch_if bus0 ();
  instr_fetch_if bus1 ();
  instr_fetch_if bus2 ();
  instr_fetch_if bus3 ();

  // Program: words 0..3 fixed, every other address returns {4'hA, addr[11:0]}
  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    case (addr)
      16'd0:   mem_word = 16'h8410;
      16'd1:   mem_word = 16'h8720;
      16'd2:   mem_word = 16'h2123;
      16'd3:   mem_word = 16'h6000;
      default: mem_word = {4'hA, addr[11:0]};
    endcase
  endfunction

  assign bus0.imem_data = mem_word(bus0.imem_addr);
  assign bus1.imem_data = mem_word(bus1.imem_addr);
  assign bus2.imem_data = mem_word(bus2.imem_addr);
  assign bus3.imem_data = mem_word(bus3.imem_addr);

  instr_fetch #(.RESET_PC(16'h0000), .PROG_LEN(16)) u_dut0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .redirect(redirect[0]),
    .redirect_pc(redirect_pc[0]), .halted(halted[0]),
    .fetch_count(fetch_count[0]), .bus(bus0)
  );

  instr_fetch #(.RESET_PC(16'h0000), .PROG_LEN(8)) u_dut1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .redirect(redirect[1]),
    .redirect_pc(redirect_pc[1]), .halted(halted[1]),
    .fetch_count(fetch_count[1]), .bus(bus1)
  );

  instr_fetch #(.RESET_PC(16'hFFFF), .PROG_LEN(32'h0000FFFF)) u_dut2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .redirect(redirect[2]),
    .redirect_pc(redirect_pc[2]), .halted(halted[2]),
    .fetch_count(fetch_count[2]), .bus(bus2)
  );

  instr_fetch #(.RESET_PC(16'hFFFF), .PROG_LEN(32'h00010000)) u_dut3 (
    .clk(clk), .rst(rst[3]), .en(en[3]), .redirect(redirect[3]),
    .redirect_pc(redirect_pc[3]), .halted(halted[3]),
    .fetch_count(fetch_count[3]), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4; i++) begin
      rst[i]         = 1'b1;
      en[i]          = 1'b0;
      redirect[i]    = 1'b0;
      redirect_pc[i] = 16'h0000;
    end
    bus0.id_ready = 1'b0;
    bus1.id_ready = 1'b0;
    bus2.id_ready = 1'b0;
    bus3.id_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;

    // Reset state
    check("rst_valid", {15'd0, bus0.if_valid}, 16'd0);
    check("rst_instr", bus0.if_instr, 16'h0000);
    check("rst_pc", bus0.if_pc, 16'h0000);
    check("rst_count", fetch_count[0], 16'd0);
    check("rst_addr", bus0.imem_addr, 16'h0000);
    check("rst_halted", {15'd0, halted[0]}, 16'd0);

    // Streaming at one word per cycle
    en[0] = 1'b1; bus0.id_ready = 1'b1;
    step();
    check("s1_instr", bus0.if_instr, 16'h8410);
    check("s1_pc", bus0.if_pc, 16'h0000);
    check("s1_valid", {15'd0, bus0.if_valid}, 16'd1);
    step();
    check("s2_instr", bus0.if_instr, 16'h8720);
    check("s2_pc", bus0.if_pc, 16'h0001);
    step();
    check("s3_instr", bus0.if_instr, 16'h2123);
    check("s3_pc", bus0.if_pc, 16'h0002);
    step();
    check("s4_instr", bus0.if_instr, 16'h6000);
    check("s4_pc", bus0.if_pc, 16'h0003);
    check("s4_count", fetch_count[0], 16'd3);
    step();
    check("s5_count", fetch_count[0], 16'd4);
    check("s5_instr", bus0.if_instr, 16'hA004);

    // Back-pressure: stall on 8720 for three cycles
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    step(2);
    check("bp_pre_instr", bus0.if_instr, 16'h8720);
    bus0.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_instr", bus0.if_instr, 16'h8720);
      check("bp_hold_pc", bus0.if_pc, 16'h0001);
      check("bp_hold_addr", bus0.imem_addr, 16'h0002);
    end
    bus0.id_ready = 1'b1;
    step();
    check("bp_rel_instr", bus0.if_instr, 16'h2123);
    check("bp_rel_pc", bus0.if_pc, 16'h0002);
    check("bp_rel_count", fetch_count[0], 16'd2);

    // Redirect while holding the word from address 5
    step(3);
    check("rd_pre_pc", bus0.if_pc, 16'h0005);
    redirect[0] = 1'b1; redirect_pc[0] = 16'h0000;
    step();
    redirect[0] = 1'b0;
    check("rd_valid", {15'd0, bus0.if_valid}, 16'd0);
    check("rd_addr", bus0.imem_addr, 16'h0000);
    check("rd_count", fetch_count[0], 16'd6);
    step();
    check("rd_instr", bus0.if_instr, 16'h8410);
    check("rd_pc", bus0.if_pc, 16'h0000);

    // Enable low: current word drains, PC frozen
    en[0] = 1'b0;
    step();
    check("en0_valid", {15'd0, bus0.if_valid}, 16'd0);
    check("en0_addr", bus0.imem_addr, 16'h0001);
    en[0] = 1'b1;
    step();
    check("en1_instr", bus0.if_instr, 16'h8720);

    // Reset wins over a simultaneous redirect
    rst[0] = 1'b1; redirect[0] = 1'b1; redirect_pc[0] = 16'h0009;
    step();
    rst[0] = 1'b0; redirect[0] = 1'b0;
    check("rr_addr", bus0.imem_addr, 16'h0000);
    check("rr_valid", {15'd0, bus0.if_valid}, 16'd0);
    check("rr_count", fetch_count[0], 16'd0);
    step();
    check("rr_instr", bus0.if_instr, 16'h8410);
    check("rr_pc", bus0.if_pc, 16'h0000);

    // End of program with PROG_LEN=8
    en[1] = 1'b1; bus1.id_ready = 1'b1;
    step(8);
    check("pl_last_pc", bus1.if_pc, 16'h0007);
    check("pl_last_halt", {15'd0, halted[1]}, 16'd0);
    step();
    check("pl_valid", {15'd0, bus1.if_valid}, 16'd0);
    check("pl_halted", {15'd0, halted[1]}, 16'd1);
    check("pl_addr", bus1.imem_addr, 16'h0008);
    check("pl_count", fetch_count[1], 16'd8);
    step();
    check("pl_addr_hold", bus1.imem_addr, 16'h0008);
    redirect[1] = 1'b1; redirect_pc[1] = 16'h0002;
    step();
    redirect[1] = 1'b0;
    check("pl_rd_halted", {15'd0, halted[1]}, 16'd0);
    step();
    check("pl_rd_instr", bus1.if_instr, 16'h2123);
    check("pl_rd_pc", bus1.if_pc, 16'h0002);

    // Top-of-space: RESET_PC=FFFF, PROG_LEN=FFFF
    check("top_rst_halted", {15'd0, halted[2]}, 16'd1);
    redirect[2] = 1'b1; redirect_pc[2] = 16'hFFFE;
    step();
    redirect[2] = 1'b0;
    check("top_rd_halted", {15'd0, halted[2]}, 16'd0);
    en[2] = 1'b1; bus2.id_ready = 1'b1;
    step();
    check("top_f_pc", bus2.if_pc, 16'hFFFE);
    check("top_f_instr", bus2.if_instr, 16'hAFFE);
    check("top_f_addr", bus2.imem_addr, 16'hFFFF);
    step();
    check("top_halted", {15'd0, halted[2]}, 16'd1);
    check("top_addr", bus2.imem_addr, 16'hFFFF);

    // PC wrap: RESET_PC=FFFF with FFFF inside the program
    check("wrap_rst_addr", bus3.imem_addr, 16'hFFFF);
    en[3] = 1'b1; bus3.id_ready = 1'b1;
    step();
    check("wrap_pc", bus3.if_pc, 16'hFFFF);
    check("wrap_addr", bus3.imem_addr, 16'h0000);
    step();
    check("wrap_instr", bus3.if_instr, 16'h8410);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
